// File: rtl/ucsbece154b_perf_pkg.sv
// Shared constants for the performance-monitor block: read-port addresses,
// run-control state encoding and the two-slot event adder.
package ucsbece154b_perf_pkg;

  localparam int PERF_NUM_CTRS = 6;

  localparam logic [2:0] PERF_ADDR_CYCLE  = 3'd0;
  localparam logic [2:0] PERF_ADDR_INSTR  = 3'd1;
  localparam logic [2:0] PERF_ADDR_BRANCH = 3'd2;
  localparam logic [2:0] PERF_ADDR_BMISS  = 3'd3;
  localparam logic [2:0] PERF_ADDR_JUMP   = 3'd4;
  localparam logic [2:0] PERF_ADDR_JMISS  = 3'd5;
  localparam logic [2:0] PERF_ADDR_STATUS = 3'd6;
  localparam logic [2:0] PERF_ADDR_ZERO   = 3'd7;

  typedef logic [1:0] perf_state_t;

  localparam perf_state_t PERF_IDLE   = 2'd0;
  localparam perf_state_t PERF_RUN    = 2'd1;
  localparam perf_state_t PERF_FROZEN = 2'd2;

  // Number of slots (0..2) that raised an event this cycle.
  function automatic logic [1:0] perf_sum2(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/ucsbece154b_perf_counters_if.sv
// Event-strobe and read-port bundle between the core and the perf counters.
interface ucsbece154b_perf_counters_if #(
  parameter int WIDTH = 32
);
  // Read port: rd_req_i is always accepted (no ready); rd_valid_o pulses for
  // exactly one cycle, one cycle after the request, with rd_data_o valid.
  logic             start_i;
  logic             stop_i;
  logic             clear_i;
  logic             issue1_i;
  logic             issue2_i;
  logic             branch1_i;
  logic             branch2_i;
  logic             jump1_i;
  logic             jump2_i;
  logic             miss1_i;
  logic             miss2_i;
  logic             rd_req_i;
  logic [2:0]       rd_addr_i;
  logic             rd_valid_o;
  logic [WIDTH-1:0] rd_data_o;
  logic             running_o;
  logic [1:0]       state_dbg;

  modport master (
    output start_i, stop_i, clear_i,
    output issue1_i, issue2_i, branch1_i, branch2_i,
    output jump1_i, jump2_i, miss1_i, miss2_i,
    output rd_req_i, rd_addr_i,
    input  rd_valid_o, rd_data_o, running_o, state_dbg
  );

  modport slave (
    input  start_i, stop_i, clear_i,
    input  issue1_i, issue2_i, branch1_i, branch2_i,
    input  jump1_i, jump2_i, miss1_i, miss2_i,
    input  rd_req_i, rd_addr_i,
    output rd_valid_o, rd_data_o, running_o, state_dbg
  );

endinterface

// File: rtl/ucsbece154b_perf_ctr.sv
// One WIDTH-bit event counter with 0..2 increment per cycle.
// Wraps by default; saturates at all-ones when PERF_SATURATE_EN is defined.
module ucsbece154b_perf_ctr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [1:0]       inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] next;

`ifdef PERF_SATURATE_EN
  logic [WIDTH:0] sum;

  assign sum  = {1'b0, count} + {{(WIDTH-1){1'b0}}, inc};
  assign next = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
  assign next = count + {{(WIDTH-2){1'b0}}, inc};
`endif

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= next;
    end
  end

endmodule

// File: rtl/ucsbece154b_perf_counters.sv
// Performance monitor: run-control FSM, six event counters, snapshot shadow
// bank and a 1-cycle registered read port. Optional macro: PERF_SATURATE_EN.
module ucsbece154b_perf_counters
  import ucsbece154b_perf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                        clk,
  input logic                        reset,
  ucsbece154b_perf_counters_if.slave bus
);

  perf_state_t      state;
  perf_state_t      state_next;
  logic             running;
  logic [1:0]       inc    [PERF_NUM_CTRS];
  logic [WIDTH-1:0] live   [PERF_NUM_CTRS];
  logic [WIDTH-1:0] shadow [1:PERF_NUM_CTRS-1];
  logic             snap;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_mux;

  // Stop wins over a simultaneous start in every state.
  always_comb begin
    state_next = state;
    case (state)
      PERF_IDLE:   if (!bus.stop_i && bus.start_i) state_next = PERF_RUN;
      PERF_RUN:    if (bus.stop_i) state_next = PERF_FROZEN;
      PERF_FROZEN: if (!bus.stop_i && bus.start_i) state_next = PERF_RUN;
      default:     state_next = PERF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= PERF_IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign running = (state == PERF_RUN);

  // A miss only counts when the same slot carries the matching branch/jump.
  assign inc[PERF_ADDR_CYCLE]  = 2'd1;
  assign inc[PERF_ADDR_INSTR]  = perf_sum2(bus.issue1_i, bus.issue2_i);
  assign inc[PERF_ADDR_BRANCH] = perf_sum2(bus.branch1_i, bus.branch2_i);
  assign inc[PERF_ADDR_BMISS]  = perf_sum2(bus.branch1_i & bus.miss1_i,
                                           bus.branch2_i & bus.miss2_i);
  assign inc[PERF_ADDR_JUMP]   = perf_sum2(bus.jump1_i, bus.jump2_i);
  assign inc[PERF_ADDR_JMISS]  = perf_sum2(bus.jump1_i & bus.miss1_i,
                                           bus.jump2_i & bus.miss2_i);

  for (genvar i = 0; i < PERF_NUM_CTRS; i++) begin : g_ctr
    ucsbece154b_perf_ctr #(
      .WIDTH (WIDTH)
    ) u_ctr (
      .clk    (clk),
      .reset  (reset),
      .clear  (bus.clear_i),
      .enable (running),
      .inc    (inc[i]),
      .count  (live[i])
    );
  end

  // Reading the cycle counter freezes a coherent copy of the other five.
  assign snap = bus.rd_req_i && (bus.rd_addr_i == PERF_ADDR_CYCLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < PERF_NUM_CTRS; i++) shadow[i] <= '0;
    end else if (bus.clear_i) begin
      for (int i = 1; i < PERF_NUM_CTRS; i++) shadow[i] <= '0;
    end else if (snap) begin
      for (int i = 1; i < PERF_NUM_CTRS; i++) shadow[i] <= live[i];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.rd_addr_i)
      PERF_ADDR_CYCLE:  rd_mux = live[0];
      PERF_ADDR_INSTR:  rd_mux = shadow[1];
      PERF_ADDR_BRANCH: rd_mux = shadow[2];
      PERF_ADDR_BMISS:  rd_mux = shadow[3];
      PERF_ADDR_JUMP:   rd_mux = shadow[4];
      PERF_ADDR_JMISS:  rd_mux = shadow[5];
      PERF_ADDR_STATUS: rd_mux = {{(WIDTH-3){1'b0}}, running, state};
      PERF_ADDR_ZERO:   rd_mux = '0;
      default:          rd_mux = '0;
    endcase
  end

  // Values are taken before this edge's clear/increment take effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_req_i;
      if (bus.rd_req_i) rd_data_q <= rd_mux;
    end
  end

  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_data_o  = rd_data_q;
  assign bus.running_o  = running;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_ucsbece154b_perf_counters.sv
// Scoreboard bench for ucsbece154b_perf_counters (32-bit instance plus a
// 4-bit instance for the wrap/saturate boundary).
module tb_ucsbece154b_perf_counters;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } probe_t;

  logic clk;
  logic reset;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] exp4_q[$];
  string       name4_q[$];
  probe_t      probe_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit done = 1'b0;
  bit reported = 1'b0;

`ifdef PERF_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  ucsbece154b_perf_counters_if #(.WIDTH(32)) b ();
  ucsbece154b_perf_counters_if #(.WIDTH(4))  c ();

  ucsbece154b_perf_counters #(.WIDTH(32)) dut  (.clk(clk), .reset(reset), .bus(b));
  ucsbece154b_perf_counters #(.WIDTH(4))  dut4 (.clk(clk), .reset(reset), .bus(c));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / monitor ----------------
  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    probe_t p;
    if (reset && b.rd_valid_o) begin
      if (exp_q.size() == 0) check("unexpected_read32", b.rd_data_o, 32'hdead_beef);
      else check(name_q.pop_front(), b.rd_data_o, exp_q.pop_front());
    end
    if (reset && c.rd_valid_o) begin
      if (exp4_q.size() == 0) check("unexpected_read4", {28'd0, c.rd_data_o}, 32'hdead_beef);
      else check(name4_q.pop_front(), {28'd0, c.rd_data_o}, exp4_q.pop_front());
    end
    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      case (p.sel)
        0:       check(p.name, {31'd0, b.running_o}, p.exp);
        1:       check(p.name, {31'd0, b.rd_valid_o}, p.exp);
        default: check(p.name, b.rd_data_o, p.exp);
      endcase
    end
    if (done && !reported) begin
      check("leftover_reads32", exp_q.size(), 0);
      check("leftover_reads4", exp4_q.size(), 0);
      reported = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(string nm, int sel, logic [31:0] exp);
    probe_t p;
    p.name = nm;
    p.sel  = sel;
    p.exp  = exp;
    probe_q.push_back(p);
  endtask

  task automatic rd(logic [2:0] addr, logic [31:0] exp, string nm);
    b.rd_req_i  = 1'b1;
    b.rd_addr_i = addr;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    cyc();
    b.rd_req_i = 1'b0;
  endtask

  task automatic rd4(logic [2:0] addr, logic [31:0] exp, string nm);
    c.rd_req_i  = 1'b1;
    c.rd_addr_i = addr;
    exp4_q.push_back(exp);
    name4_q.push_back(nm);
    cyc();
    c.rd_req_i = 1'b0;
  endtask

  task automatic set_events(logic i1, logic i2, logic b1, logic b2,
                            logic j1, logic j2, logic m1, logic m2);
    b.issue1_i = i1;  b.issue2_i = i2;
    b.branch1_i = b1; b.branch2_i = b2;
    b.jump1_i = j1;   b.jump2_i = j2;
    b.miss1_i = m1;   b.miss2_i = m2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    b.start_i = 0; b.stop_i = 0; b.clear_i = 0; b.rd_req_i = 0; b.rd_addr_i = 3'd0;
    set_events(0, 0, 0, 0, 0, 0, 0, 0);
    c.start_i = 0; c.stop_i = 0; c.clear_i = 0; c.rd_req_i = 0; c.rd_addr_i = 3'd0;
    c.issue1_i = 0; c.issue2_i = 0; c.branch1_i = 0; c.branch2_i = 0;
    c.jump1_i = 0; c.jump2_i = 0; c.miss1_i = 0; c.miss2_i = 0;

    cyc();
    probe("reset_running", 0, 0);
    probe("reset_rd_valid", 1, 0);
    probe("reset_rd_data", 2, 0);
    cyc();
    reset = 1'b1;
    cyc();

    // Start, 10 counted cycles with both slots issuing; stop rides on the 10th.
    b.start_i = 1; cyc(); b.start_i = 0;
    set_events(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (9) cyc();
    b.stop_i = 1; cyc(); b.stop_i = 0;
    set_events(0, 0, 0, 0, 0, 0, 0, 0);
    probe("t1_running_after_stop", 0, 0);
    rd(3'd0, 10, "t1_cycles");
    rd(3'd1, 20, "t1_instr");
    rd(3'd6, 2, "t1_status_frozen");
    rd(3'd2, 0, "t1_branches");
    rd(3'd5, 0, "t1_jmiss");

    // Branch/miss mix, then stray miss2 strobes that must be ignored.
    b.clear_i = 1; cyc(); b.clear_i = 0;
    b.start_i = 1; cyc(); b.start_i = 0;
    probe("t2_running", 0, 1);
    set_events(0, 0, 1, 1, 0, 0, 1, 0);
    repeat (3) cyc();
    set_events(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (5) cyc();
    set_events(0, 0, 0, 0, 0, 0, 0, 0);
    b.stop_i = 1; cyc(); b.stop_i = 0;
    rd(3'd0, 9, "t2_cycles");
    rd(3'd1, 0, "t2_instr");
    rd(3'd2, 6, "t2_branches");
    rd(3'd3, 3, "t2_bmiss");
    rd(3'd4, 0, "t2_jumps");
    rd(3'd5, 0, "t2_jmiss");

    // Jumps, then a snapshot while events keep flowing.
    b.start_i = 1; cyc(); b.start_i = 0;
    set_events(0, 0, 0, 0, 1, 1, 1, 1);
    repeat (2) cyc();
    set_events(0, 0, 0, 0, 0, 1, 0, 0);
    cyc();
    set_events(1, 0, 1, 0, 0, 0, 0, 0);
    rd(3'd0, 12, "t3_snap_cycles");
    set_events(1, 1, 0, 1, 1, 0, 0, 1);
    repeat (3) cyc();
    set_events(0, 0, 0, 0, 0, 0, 0, 0);
    rd(3'd1, 0, "t3_shadow_instr");
    rd(3'd2, 6, "t3_shadow_branches");
    rd(3'd3, 3, "t3_shadow_bmiss");
    rd(3'd4, 5, "t3_shadow_jumps");
    rd(3'd5, 4, "t3_shadow_jmiss");
    rd(3'd0, 21, "t3_live_cycles");
    rd(3'd1, 7, "t3_new_instr");
    rd(3'd2, 10, "t3_new_branches");
    rd(3'd3, 6, "t3_new_bmiss");
    rd(3'd4, 8, "t3_new_jumps");
    rd(3'd5, 4, "t3_new_jmiss");
    rd(3'd6, 5, "t3_status_run");
    rd(3'd7, 0, "t3_addr7");

    // Clear with a same-cycle increment and read.
    b.issue1_i = 1; b.clear_i = 1;
    rd(3'd1, 7, "t4_read_during_clear");
    b.issue1_i = 0; b.clear_i = 0;
    rd(3'd1, 0, "t4_shadow_after_clear");
    rd(3'd0, 1, "t4_cycles_after_clear");
    rd(3'd1, 0, "t4_instr_after_clear");

    // Start and stop together: stop wins in RUN and in FROZEN.
    b.start_i = 1; b.stop_i = 1; cyc();
    probe("t5_run_start_stop", 0, 0);
    cyc();
    b.start_i = 0; b.stop_i = 0;
    rd(3'd6, 2, "t5_status_frozen");

    // 4-bit instance: instructions to 14, then +2 twice.
    c.start_i = 1; cyc(); c.start_i = 0;
    c.issue1_i = 1; c.issue2_i = 1;
    repeat (6) cyc();
    c.stop_i = 1; cyc(); c.stop_i = 0;
    rd4(3'd0, 7, "t6_cycles_7");
    rd4(3'd1, 14, "t6_instr_14");
    c.start_i = 1; cyc(); c.start_i = 0;
    c.stop_i = 1; cyc(); c.stop_i = 0;
    rd4(3'd0, 8, "t6_cycles_8");
    rd4(3'd1, SAT ? 32'd15 : 32'd0, "t6_instr_plus2_from_14");
    c.start_i = 1; cyc(); c.start_i = 0;
    c.stop_i = 1; cyc(); c.stop_i = 0;
    rd4(3'd0, 9, "t6_cycles_9");
    rd4(3'd1, SAT ? 32'd15 : 32'd2, "t6_instr_plus2_again");
    c.issue1_i = 0; c.issue2_i = 0;

    // Reset while a read response is on the port: it must vanish at once.
    b.rd_req_i = 1; b.rd_addr_i = 3'd0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    b.rd_req_i = 0;
    probe("t7_rd_valid_in_reset", 1, 0);
    probe("t7_rd_data_in_reset", 2, 0);
    probe("t7_running_in_reset", 0, 0);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    rd(3'd6, 0, "t7_status_idle");
    rd(3'd0, 0, "t7_cycles_cleared");
    b.start_i = 1; b.stop_i = 1; cyc();
    b.start_i = 0; b.stop_i = 0;
    probe("t7_idle_start_stop", 0, 0);
    rd(3'd6, 0, "t7_status_still_idle");

    cyc();
    done = 1'b1;
    for (int i = 0; i < 10 && !reported; i++) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_perf_counters.md
# ucsbece154b_perf_counters

Hardware performance-monitor block for the two-wide superscalar core. It counts cycles, issued instructions, branches, branch mispredictions, jumps and jump mispredictions from per-cycle Execute-stage event strobes driven by the datapath. Counts are exposed through a registered read port, so software and benches can read CPI and prediction statistics without hierarchical probes. Instantiated inside `ucsbece154b_riscv`, beside the datapath and controller.

## Interface
- `WIDTH`, 32, width of every counter and of `rd_data_o`
- `clk`  in  1  core clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately
- `start_i`  in  1  strobe: begin/resume counting
- `stop_i`  in  1  strobe: freeze counting
- `clear_i`  in  1  strobe: zero all counters
- `issue1_i`  in  1  slot-1 instruction valid in Execute
- `issue2_i`  in  1  slot-2 instruction valid in Execute
- `branch1_i`, `branch2_i`  in  1 each  conditional branch in Execute, per slot
- `jump1_i`, `jump2_i`  in  1 each  jal/jalr in Execute, per slot
- `miss1_i`, `miss2_i`  in  1 each  misprediction resolved in Execute, per slot
- `rd_req_i`  in  1  read request
- `rd_addr_i`  in  3  counter select
- `rd_valid_o`  out  1  read data valid pulse
- `rd_data_o`  out  WIDTH  read data
- `running_o`  out  1  high in RUN state

## Operation
- Run-control FSM: IDLE (reset state) -> RUN on `start_i`; RUN -> FROZEN on `stop_i`; FROZEN -> RUN on `start_i`. `clear_i` does not change state. `start_i` and `stop_i` together: `stop_i` wins (IDLE stays IDLE, RUN -> FROZEN).
- Counting happens only in RUN; IDLE and FROZEN hold counts.
- Addresses: 0 cycles, 1 instructions, 2 branches, 3 branch misses, 4 jumps, 5 jump misses, 6 status {running, state[1:0]} zero-extended, 7 reads 0.
- Per RUN cycle: cycles +1; instructions + (`issue1_i`+`issue2_i`), increment of 0..2; branches + (`branch1_i`+`branch2_i`); branch misses + (`branch1_i&miss1_i` + `branch2_i&miss2_i`); jumps and jump misses likewise with `jumpN_i`.
- `missN_i` without the matching `branchN_i`/`jumpN_i` is ignored. An event strobe without `issueN_i` is still counted (the producer qualifies it).
- Snapshot: a read of address 0 latches all counters into a shadow bank in the same edge. Reads of addresses 1-5 return the shadow value, so one read sequence gives a coherent set.
- `clear_i` zeroes live counters and the shadow bank. Clear beats a same-cycle increment: the counter is 0 afterwards.

## Timing
- Reset: all counters and the shadow bank 0, state IDLE, `rd_valid_o`=0, `rd_data_o`=0, `running_o`=0.
- Strobes are sampled at edge N. The updated count is visible at edge N+1 through a read issued in cycle N+1.
- The state changes at the edge that samples the strobe. The cycle that samples `start_i` counts as cycle 0; the first count happens at the next edge.
- Read latency is 1: `rd_req_i` at edge N gives `rd_valid_o`=1 and `rd_data_o` during cycle N+1. Back-to-back reads are allowed every cycle. `rd_data_o` holds its last value while `rd_valid_o`=0.
- A read in the same cycle as `clear_i` returns the pre-clear value.
- A read of address 0 returns the live pre-increment cycle count and latches the shadow bank from the same pre-increment values.
- `reset` asserted mid-operation: all state is cleared asynchronously and any in-flight read is dropped (`rd_valid_o` goes to 0).

## Configuration
- `PERF_SATURATE_EN` defined: every counter saturates at 2^WIDTH-1. An increment of 2 from 2^WIDTH-2 lands on 2^WIDTH-1.
- Not defined: counters wrap modulo 2^WIDTH. From 2^WIDTH-1, +2 gives 1.

## Structure
- Package `ucsbece154b_perf_pkg` holds the address constants (`PERF_ADDR_CYCLE` .. `PERF_ADDR_JMISS`) and the FSM state encoding (IDLE=0, RUN=1, FROZEN=2).
- Sub-module `ucsbece154b_perf_ctr` is a single WIDTH counter. Inputs: increment amount (2 bits), clear, enable. It contains the saturate/wrap logic and is instantiated six times.

## Test plan
- Reset, then `start_i`, 10 cycles with both issues high, then `stop_i` -> cycles=10, instructions=20, `running_o`=0.
- In RUN: `branch1_i`&`miss1_i` and `branch2_i` (no miss) for 3 cycles -> branches=6, branch misses=3.
- `miss2_i` with no branch/jump for 5 cycles -> all miss counters stay 0.
- `clear_i` and `issue1_i` in the same RUN cycle, and a read of address 1 in that cycle -> read returns the old value; the next read returns 0.
- Read address 0, then 3 more RUN cycles of events, then read 1-5 -> shadow values from the address-0 read are returned, not the live ones.
- WIDTH=4, counter preset by running to 14, one cycle with both issues -> 15 with `PERF_SATURATE_EN`, 0 without; `reset` low mid-read -> `rd_valid_o`=0 immediately.
